valid_flop_pipe: RTL and testbench
==================================

Name: valid_flop_pipe

Overview:
- Multi-stage forward-registered valid/ready pipeline for the handshake library.
- It is the opposite-direction counterpart of the existing ready-path register. Here the forward path (valid_down, data_down) is registered at every stage, and ready propagates combinationally backward.
- Empty stages collapse bubbles, so an empty stage accepts data even while downstream stalls.
- Used where a long forward path (valid/data) must be retimed without losing throughput. An occupancy count is provided for debug and flow monitoring.

Parameters:
- WIDTH, 4, data bus width in bits.
- STAGES, 2, number of register stages (legal values are 1 and above); equals the minimum latency in cycles.
- CW, $clog2(STAGES+1), width of the count output (derived; not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-high.
- valid_up  input  1  upstream data valid.
- data_up  input  WIDTH  upstream data.
- ready_up  output  1  pipeline can accept (combinational).
- valid_down  output  1  downstream data valid (registered).
- data_down  output  WIDTH  downstream data (registered).
- ready_down  input  1  downstream can accept.
- count  output  CW  number of occupied stages (registered).

Behaviour:
- State per stage i (0..STAGES-1): v[i], d[i]. Stage STAGES-1 drives valid_down = v[STAGES-1] and data_down = d[STAGES-1].
- Ready chain: r[STAGES] = ready_down; r[i] = !v[i] | r[i+1]; ready_up = r[0] & !rst.
- A stage's input source is valid_up/data_up for stage 0, and stage i-1 otherwise.
- Stage update on each clock where r[i] = 1: v[i] <= source valid. d[i] <= source data only when the source valid is 1; otherwise d[i] holds.
- Stage update on each clock where r[i] = 0: v[i] and d[i] hold.
- Transfer definitions:
  - Input transfer: valid_up & ready_up.
  - Output transfer: valid_down & ready_down.
- Latency: an item accepted at edge N first appears at valid_down after edge N+STAGES-1 when there is no stall. STAGES=1 gives one cycle from acceptance to visibility.
- Throughput: one item per cycle when ready_down is held at 1.
- Ordering: strict FIFO order. No item is dropped or duplicated.
- AXI-style output rules: once valid_down=1, it stays at 1, and data_down stays stable, until ready_down=1.
- Full condition: all v=1 and ready_down=0 → ready_up=0 and all state holds.
- Empty condition: all v=0 → valid_down=0 and ready_up=1.
- Count update:
  - +1 on an input transfer only.
  - -1 on an output transfer only.
  - Unchanged when both or neither occur.
  - Range is 0..STAGES; it never wraps.
- Simultaneous input and output transfer while full: accepted, because the ready chain passes through. Count is unchanged.
- Reset (rst=1 at an edge): all v <= 0, all d <= 0, count <= 0.
  - ready_up is forced to 0 while rst=1, so no upstream transfer occurs during reset.
  - Reset mid-operation discards all contents. No pre-reset item appears at the output afterwards.
- Reset values: valid_down=0, data_down=0, count=0. ready_up=0 while rst is high, and 1 on the first cycle after rst deasserts.
- No combinational path from valid_up or data_up to valid_down or data_down. The only combinational path is ready_down → ready_up.

Test Plan:
All scenarios use WIDTH=4, STAGES=2.
1. Reset: hold rst=1 for 2 cycles with valid_up=1, data_up=4'hF → ready_up=0, valid_down=0, data_down=0, count=0; after release, ready_up=1 and no 4'hF is ever emitted.
2. Streaming: ready_down=1, valid_up=1, data_up=1..8 on consecutive cycles → data_down=1..8 on consecutive cycles, first item valid one edge after its acceptance edge; count=2 in steady state; ready_up constant 1.
3. Backpressure: ready_down=0, offer 1, 2, 3 → 1 and 2 accepted, ready_up=0 when 3 is offered, count=2, valid_down=1 with data_down=1 held stable. Set ready_down=1 → output 1, 2, 3 in order with no loss or duplication; count returns to 0 after draining.
4. Bubble collapse: accept 5, idle one cycle, then ready_down=0 → 5 is in stage 1 and stage 0 is empty; offer 6 → accepted, count=2, ready_up then 0.
5. Simultaneous: pipeline full (count=2), then ready_down=1 and valid_up=1 with data 9 in the same cycle → one item emitted and 9 accepted; count stays 2; ready_up=1 that cycle.
6. Reset mid-operation: pipeline full holding 3 and 4 with ready_down=0, pulse rst for 1 cycle → next cycle valid_down=0 and count=0. Set ready_down=1 → neither 3 nor 4 ever appears. A subsequent push of 7 appears normally.

Source files
------------

// File: rtl/valid_flop_pipe.sv
// Forward-registered valid/ready pipeline: valid/data flop at every stage, ready
// ripples combinationally backward so empty stages absorb bubbles.

module valid_flop_stage #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             src_v,
    input  logic [WIDTH-1:0] src_d,
    output logic             v,
    output logic [WIDTH-1:0] d
);
    always_ff @(posedge clk) begin
        if (rst) begin
            v <= 1'b0;
            d <= '0;
        end else if (en) begin
            v <= src_v;
            if (src_v) d <= src_d;
        end
    end
endmodule

module valid_flop_pipe #(
    parameter  int WIDTH  = 4,
    parameter  int STAGES = 2,
    localparam int CW     = $clog2(STAGES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_up,
    input  logic [WIDTH-1:0] data_up,
    output logic             ready_up,
    output logic             valid_down,
    output logic [WIDTH-1:0] data_down,
    input  logic             ready_down,
    output logic [CW-1:0]    count
);
    logic [STAGES-1:0]            vld_pipe;
    logic [STAGES-1:0][WIDTH-1:0] dat_pipe;
    logic [STAGES:0]              rdy;
    logic                         in_xfer, out_xfer;

    // A stage advances when it is empty or the stage ahead of it advances.
    assign rdy[STAGES] = ready_down;

    for (genvar i = 0; i < STAGES; i++) begin : g_stage
        logic             src_v;
        logic [WIDTH-1:0] src_d;

        if (i == 0) begin : g_head
            assign src_v = valid_up;
            assign src_d = data_up;
        end else begin : g_body
            assign src_v = vld_pipe[i-1];
            assign src_d = dat_pipe[i-1];
        end

        assign rdy[i] = ~vld_pipe[i] | rdy[i+1];

        valid_flop_stage #(.WIDTH(WIDTH)) u_stage (
            .clk   (clk),
            .rst   (rst),
            .en    (rdy[i]),
            .src_v (src_v),
            .src_d (src_d),
            .v     (vld_pipe[i]),
            .d     (dat_pipe[i])
        );
    end

    assign ready_up   = rdy[0] & ~rst;
    assign valid_down = vld_pipe[STAGES-1];
    assign data_down  = dat_pipe[STAGES-1];

    assign in_xfer  = valid_up & ready_up;
    assign out_xfer = valid_down & ready_down;

    always_ff @(posedge clk) begin
        if (rst)
            count <= '0;
        else if (in_xfer & ~out_xfer)
            count <= count + CW'(1);
        else if (~in_xfer & out_xfer)
            count <= count - CW'(1);
    end
endmodule

// File: tb/tb_valid_flop_pipe.sv
// Directed bench for valid_flop_pipe (WIDTH=4, STAGES=2): driver pushes expected
// items into a queue on acceptance, a negedge monitor pops them on output transfers.

module tb_valid_flop_pipe;
    logic       clk = 1'b0;
    logic       rst;
    logic       valid_up;
    logic [3:0] data_up;
    logic       ready_up;
    logic       valid_down;
    logic [3:0] data_down;
    logic       ready_down;
    logic [1:0] count;

    int         n_vec = 0;
    int         n_err = 0;
    logic [3:0] exp_q[$];
    logic       prev_hold = 1'b0;
    logic [3:0] prev_data = '0;

    always #5 clk = ~clk;

    valid_flop_pipe #(.WIDTH(4), .STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_up   (valid_up),
        .data_up    (data_up),
        .ready_up   (ready_up),
        .valid_down (valid_down),
        .data_down  (data_down),
        .ready_down (ready_down),
        .count      (count)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle: inputs set just after posedge, checks at negedge, then the edge.
    task automatic step(input string nm, input logic v, input logic [3:0] d, input logic rd,
                        input logic exp_rdy, input logic [1:0] exp_cnt, input logic exp_vd);
        valid_up   = v;
        data_up    = d;
        ready_down = rd;
        @(negedge clk);
        chk({nm, ".ready_up"}, 32'(ready_up), 32'(exp_rdy));
        chk({nm, ".count"}, 32'(count), 32'(exp_cnt));
        chk({nm, ".valid_down"}, 32'(valid_down), 32'(exp_vd));
        if (v && exp_rdy) exp_q.push_back(d);
        @(posedge clk);
        #1;
    endtask

    // Monitor: order/content of every output transfer plus hold stability under stall.
    always @(negedge clk) begin
        if (rst) begin
            prev_hold <= 1'b0;
        end else begin
            if (prev_hold) begin
                chk("hold.valid_down", 32'(valid_down), 32'd1);
                chk("hold.data_down", 32'(data_down), 32'(prev_data));
            end
            if (valid_down && ready_down) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(data_down), 32'hdead);
                end else begin
                    chk("out_data", 32'(data_down), 32'(exp_q.pop_front()));
                end
            end
            prev_hold <= valid_down & ~ready_down;
            prev_data <= data_down;
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. reset with an item offered
        rst = 1'b1; valid_up = 1'b1; data_up = 4'hF; ready_down = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst.ready_up", 32'(ready_up), 32'd0);
            chk("rst.valid_down", 32'(valid_down), 32'd0);
            chk("rst.data_down", 32'(data_down), 32'd0);
            chk("rst.count", 32'(count), 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        step("rst_rel", 0, 4'h0, 1, 1, 0, 0);

        // 2. streaming 1..8
        for (int k = 1; k <= 8; k++)
            step("stream", 1, 4'(k), 1, 1, (k == 1) ? 2'd0 : (k == 2) ? 2'd1 : 2'd2, k >= 3);
        step("stream_drain", 0, 4'h0, 1, 1, 2, 1);
        step("stream_drain", 0, 4'h0, 1, 1, 1, 1);
        step("stream_empty", 0, 4'h0, 1, 1, 0, 0);

        // 3. backpressure
        step("bp", 1, 4'h1, 0, 1, 0, 0);
        step("bp", 1, 4'h2, 0, 1, 1, 0);
        step("bp_full", 1, 4'h3, 0, 0, 2, 1);
        @(negedge clk);
        chk("bp_full.data_down", 32'(data_down), 32'h1);
        @(posedge clk); #1;
        step("bp_full", 1, 4'h3, 0, 0, 2, 1);
        step("bp_release", 1, 4'h3, 1, 1, 2, 1);
        step("bp_drain", 0, 4'h0, 1, 1, 2, 1);
        step("bp_drain", 0, 4'h0, 1, 1, 1, 1);
        step("bp_empty", 0, 4'h0, 1, 1, 0, 0);

        // 4. bubble collapse
        step("bubble", 1, 4'h5, 1, 1, 0, 0);
        step("bubble_idle", 0, 4'h0, 1, 1, 1, 0);
        step("bubble_fill", 1, 4'h6, 0, 1, 1, 1);
        step("bubble_full", 0, 4'h0, 0, 0, 2, 1);
        step("bubble_drain", 0, 4'h0, 1, 1, 2, 1);
        step("bubble_drain", 0, 4'h0, 1, 1, 1, 1);
        step("bubble_empty", 0, 4'h0, 1, 1, 0, 0);

        // 5. simultaneous in/out while full
        step("sim_fill", 1, 4'hA, 0, 1, 0, 0);
        step("sim_fill", 1, 4'hB, 0, 1, 1, 0);
        step("sim_both", 1, 4'h9, 1, 1, 2, 1);
        step("sim_after", 0, 4'h0, 1, 1, 2, 1);
        step("sim_drain", 0, 4'h0, 1, 1, 1, 1);
        step("sim_empty", 0, 4'h0, 1, 1, 0, 0);

        // 6. reset mid-operation discards contents
        step("mid_fill", 1, 4'h3, 0, 1, 0, 0);
        step("mid_fill", 1, 4'h4, 0, 1, 1, 0);
        rst = 1'b1; valid_up = 1'b1; data_up = 4'h8; ready_down = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("mid_rst.ready_up", 32'(ready_up), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("mid_post", 0, 4'h0, 1, 1, 0, 0);
        step("mid_post", 0, 4'h0, 1, 1, 0, 0);
        step("mid_push", 1, 4'h7, 1, 1, 0, 0);
        step("mid_lat", 0, 4'h0, 1, 1, 1, 0);
        step("mid_out", 0, 4'h0, 1, 1, 1, 1);
        step("mid_empty", 0, 4'h0, 1, 1, 0, 0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
